// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: result class encoding and packed-word constants.
// Imported by the classifier, the arithmetic units and the result packer.
package bf16_pkg;

    typedef enum logic [1:0] {
        FIN  = 2'd0,
        INF  = 2'd1,
        NAN  = 2'd2,
        ZERO = 2'd3
    } cls_e;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [15:0] QNAN     = 16'h7FC0;
    localparam logic [14:0] INF_MAG  = 15'h7F80;
    localparam logic [14:0] ZERO_MAG = 15'h0000;

endpackage

// File: rtl/bf16_pack_if.sv
// Handshake bundle between the arithmetic datapath, the result packer and its consumer.
// master drives the unpacked result and out_ready; slave is the packer.
interface bf16_pack_if #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 16
) ();

    logic               in_valid;
    logic               in_ready;
    bf16_pkg::cls_e     in_cls;
    logic               in_sign;
    logic [EXP_W-1:0]   in_exp;
    logic [MANT_W-1:0]  in_mant;

    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_result;
    logic               out_overflow;
    logic               out_underflow;
    logic               out_inexact;

    modport master (
        output in_valid, in_cls, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

    modport slave (
        input  in_valid, in_cls, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
    );

endinterface

// File: rtl/bf16_round.sv
// Round-to-nearest-even of a normalized mantissa to 8 kept bits (hidden + 7).
// Purely combinational; a carry out of the kept bits renormalizes to 0x80 and bumps exp.
module bf16_round #(
    parameter int MANT_W = 16,
    parameter int EW     = 11
) (
    input  logic [MANT_W-1:0] mant,
    input  logic [EW-1:0]     exp_in,
    output logic [7:0]        kept,
    output logic [EW-1:0]     exp_out,
    output logic              inexact,
    output logic              carry
);

    logic       guard;
    logic       sticky;
    logic       round_up;
    logic [8:0] sum;

    always_comb begin
        guard    = mant[MANT_W-9];
        sticky   = |mant[MANT_W-10:0];
        round_up = guard & (sticky | mant[MANT_W-8]);
        sum      = {1'b0, mant[MANT_W-1 -: 8]} + {8'd0, round_up};
        carry    = sum[8];
        kept     = carry ? 8'h80 : sum[7:0];
        exp_out  = exp_in + {{(EW-1){1'b0}}, carry};
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/bf16_pack.sv
// bfloat16 result packer: iterative normalize, round-to-nearest-even, range check,
// then hold the packed word and flags until the consumer takes it.
module bf16_pack
    import bf16_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    bf16_pack_if.slave pk
);

    localparam int EW = EXP_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state;
    logic [MANT_W-1:0] mant_r;
    logic [EW-1:0]     exp_r;
    logic              sign_r;

    logic [7:0]        rnd_kept;
    logic [EW-1:0]     rnd_exp;
    logic              rnd_inexact;
    logic              rnd_carry;
    logic              unused_rnd;

    logic              exp_hi;
    logic              exp_lo;

    bf16_round #(
        .MANT_W (MANT_W),
        .EW     (EW)
    ) u_round (
        .mant    (mant_r),
        .exp_in  (exp_r),
        .kept    (rnd_kept),
        .exp_out (rnd_exp),
        .inexact (rnd_inexact),
        .carry   (rnd_carry)
    );

    // Hidden bit is implied by normalization; carry is already folded into rnd_exp.
    assign unused_rnd = rnd_kept[7] ^ rnd_carry;

    assign exp_hi = !rnd_exp[EW-1] && (rnd_exp >= EW'(EXP_MAX));
    assign exp_lo = rnd_exp[EW-1] || (rnd_exp == '0);

    assign pk.in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            mant_r           <= '0;
            exp_r            <= '0;
            sign_r           <= 1'b0;
            pk.out_valid     <= 1'b0;
            pk.out_result    <= '0;
            pk.out_overflow  <= 1'b0;
            pk.out_underflow <= 1'b0;
            pk.out_inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pk.in_valid) begin
                        pk.out_overflow  <= 1'b0;
                        pk.out_underflow <= 1'b0;
                        pk.out_inexact   <= 1'b0;
                        case (pk.in_cls)
                            NAN: begin
                                pk.out_result <= QNAN;
                                pk.out_valid  <= 1'b1;
                                state         <= DONE;
                            end
                            INF: begin
                                pk.out_result <= {pk.in_sign, INF_MAG};
                                pk.out_valid  <= 1'b1;
                                state         <= DONE;
                            end
                            ZERO: begin
                                pk.out_result <= {pk.in_sign, ZERO_MAG};
                                pk.out_valid  <= 1'b1;
                                state         <= DONE;
                            end
                            default: begin
                                if (pk.in_mant == '0) begin
                                    pk.out_result <= {pk.in_sign, ZERO_MAG};
                                    pk.out_valid  <= 1'b1;
                                    state         <= DONE;
                                end else begin
                                    sign_r <= pk.in_sign;
                                    mant_r <= pk.in_mant;
                                    exp_r  <= {pk.in_exp[EXP_W-1], pk.in_exp};
                                    // Look one bit ahead so NORM spends exactly one cycle per leading zero.
                                    state  <= pk.in_mant[MANT_W-1] ? ROUND : NORM;
                                end
                            end
                        endcase
                    end
                end

                NORM: begin
                    mant_r <= {mant_r[MANT_W-2:0], 1'b0};
                    exp_r  <= exp_r - {{(EW-1){1'b0}}, 1'b1};
                    if (mant_r[MANT_W-2]) begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    if (exp_hi) begin
                        pk.out_result   <= {sign_r, INF_MAG};
                        pk.out_overflow <= 1'b1;
                        pk.out_inexact  <= 1'b1;
                    end else if (exp_lo) begin
                        pk.out_result    <= {sign_r, ZERO_MAG};
                        pk.out_underflow <= 1'b1;
                        pk.out_inexact   <= 1'b1;
                    end else begin
                        pk.out_result  <= {sign_r, rnd_exp[7:0], rnd_kept[6:0]};
                        pk.out_inexact <= rnd_inexact;
                    end
                    pk.out_valid <= 1'b1;
                    state        <= DONE;
                end

                DONE: begin
                    if (pk.out_ready) begin
                        pk.out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_pack.sv
// Directed bench for bf16_pack: hand-computed packed words, flags, latency, stall and reset.
module tb_bf16_pack;
    import bf16_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bf16_pack_if #(.EXP_W(10), .MANT_W(16)) pk ();

    bf16_pack #(.EXP_W(10), .MANT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .pk  (pk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Latency counts clock edges from the accept edge (inclusive) to the edge raising out_valid.
    task automatic run_txn(input string name, input cls_e cls, input logic sign,
                           input logic [9:0] e, input logic [15:0] m,
                           input logic [15:0] res, input logic ov, input logic uf,
                           input logic ix, input int lat, input int hold);
        int n;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(pk.in_ready), 32'd1);
        pk.in_cls   = cls;
        pk.in_sign  = sign;
        pk.in_exp   = e;
        pk.in_mant  = m;
        pk.in_valid = 1'b1;
        pk.out_ready = 1'b0;
        @(posedge clk);
        #1;
        pk.in_valid = 1'b0;
        n = 1;
        while (!pk.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ".latency"}, 32'(n), 32'(lat));
        check({name, ".result"}, 32'(pk.out_result), 32'(res));
        check({name, ".overflow"}, 32'(pk.out_overflow), 32'(ov));
        check({name, ".underflow"}, 32'(pk.out_underflow), 32'(uf));
        check({name, ".inexact"}, 32'(pk.out_inexact), 32'(ix));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_valid"}, 32'(pk.out_valid), 32'd1);
            check({name, ".hold_in_ready"}, 32'(pk.in_ready), 32'd0);
            check({name, ".hold_result"}, 32'(pk.out_result), 32'(res));
            check({name, ".hold_flags"},
                  32'({pk.out_overflow, pk.out_underflow, pk.out_inexact}),
                  32'({ov, uf, ix}));
        end
        @(negedge clk);
        pk.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, ".post_in_ready"}, 32'(pk.in_ready), 32'd1);
        check({name, ".post_valid"}, 32'(pk.out_valid), 32'd0);
        @(negedge clk);
        pk.out_ready = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        pk.in_valid  = 1'b0;
        pk.in_cls    = FIN;
        pk.in_sign   = 1'b0;
        pk.in_exp    = '0;
        pk.in_mant   = '0;
        pk.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.in_ready", 32'(pk.in_ready), 32'd1);
        check("reset.out_valid", 32'(pk.out_valid), 32'd0);
        check("reset.out_result", 32'(pk.out_result), 32'h0000);
        check("reset.flags", 32'({pk.out_overflow, pk.out_underflow, pk.out_inexact}), 32'd0);

        //        name          cls   s     exp      mant      result   ov    uf    ix   lat hold
        run_txn("one",         FIN,  1'b0, 10'd127, 16'h8000, 16'h3F80, 1'b0, 1'b0, 1'b0, 2, 3);
        run_txn("lz15",        FIN,  1'b0, 10'd142, 16'h0001, 16'h3F80, 1'b0, 1'b0, 1'b0, 17, 0);
        run_txn("uflow_lz1",   FIN,  1'b1, 10'd1,   16'h4000, 16'h8000, 1'b0, 1'b1, 1'b1, 3, 0);
        run_txn("rnd_up",      FIN,  1'b0, 10'd127, 16'h8180, 16'h3F82, 1'b0, 1'b0, 1'b1, 2, 0);
        run_txn("rnd_tie_even",FIN,  1'b0, 10'd127, 16'h8080, 16'h3F80, 1'b0, 1'b0, 1'b1, 2, 0);
        run_txn("rnd_sticky",  FIN,  1'b0, 10'd127, 16'h8001, 16'h3F80, 1'b0, 1'b0, 1'b1, 2, 0);
        run_txn("rnd_carry",   FIN,  1'b0, 10'd127, 16'hFF80, 16'h4000, 1'b0, 1'b0, 1'b1, 2, 0);
        run_txn("oflow_carry", FIN,  1'b0, 10'd254, 16'hFFFF, 16'h7F80, 1'b1, 1'b0, 1'b1, 2, 0);
        run_txn("oflow_big",   FIN,  1'b1, 10'd300, 16'h8000, 16'hFF80, 1'b1, 1'b0, 1'b1, 2, 0);
        run_txn("uflow_neg",   FIN,  1'b0, 10'h3FB, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 2, 0);
        run_txn("nan",         NAN,  1'b1, 10'd5,   16'h1234, 16'h7FC0, 1'b0, 1'b0, 1'b0, 1, 0);
        run_txn("inf",         INF,  1'b1, 10'd5,   16'h1234, 16'hFF80, 1'b0, 1'b0, 1'b0, 1, 0);
        run_txn("zero",        ZERO, 1'b1, 10'd5,   16'h1234, 16'h8000, 1'b0, 1'b0, 1'b0, 1, 0);
        run_txn("fin_zero",    FIN,  1'b1, 10'd127, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1, 0);

        // Reset in the middle of a long normalization.
        @(negedge clk);
        pk.in_cls   = FIN;
        pk.in_sign  = 1'b0;
        pk.in_exp   = 10'd142;
        pk.in_mant  = 16'h0001;
        pk.in_valid = 1'b1;
        @(posedge clk);
        #1;
        pk.in_valid = 1'b0;
        check("midnorm.busy", 32'(pk.in_ready), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midnorm.in_ready", 32'(pk.in_ready), 32'd1);
        check("midnorm.out_valid", 32'(pk.out_valid), 32'd0);
        check("midnorm.out_result", 32'(pk.out_result), 32'h0000);
        @(negedge clk);
        rst = 1'b0;

        run_txn("after_rst",   FIN,  1'b1, 10'd128, 16'h4000, 16'hBF80, 1'b0, 1'b0, 1'b0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
